stream_scaled_accumulator: RTL and testbench
============================================

// Module: stream_scaled_accumulator
// PURPOSE
//  Multi-lane successor to the combinational signed adder. Each lane sums a stream of
//  signed operands into a saturating accumulator and emits one scaled, rounded,
//  saturated result per transaction. Sits after the PE array, feeding requantisation.
//  Valid/ready handshake on both sides, so it slots into the streaming datapath.
// PARAMETERS
//  LANES      4   independent accumulation lanes
//  IN_WIDTH   16  signed operand width per lane
//  ACC_WIDTH  32  signed accumulator width per lane (must be > IN_WIDTH)
//  OUT_WIDTH  16  signed result width per lane (must be <= ACC_WIDTH)
//  OUT_SCALE  0   arithmetic right shift applied to the final accumulator
//  ROUND      1   1: add 2^(OUT_SCALE-1) before shift (round half up); 0: truncate
// PORTS
//  clk        in   1                clock, rising edge
//  arst_n_in  in   1                asynchronous reset, active low
//  in_valid   in   1                input beat valid
//  in_ready   out  1                block can accept a beat
//  in_last    in   1                beat is the final one of the transaction
//  in_data    in   LANES*IN_WIDTH   lane i = bits [i*IN_WIDTH +: IN_WIDTH], signed
//  out_valid  out  1                result valid
//  out_ready  in   1                downstream accepts result
//  out_data   out  LANES*OUT_WIDTH  lane i = bits [i*OUT_WIDTH +: OUT_WIDTH], signed
//  out_sat    out  LANES            lane i saturated (accumulator or output clamp)
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous, active low (arst_n_in). While arst_n_in=0:
//    state=IDLE, accumulators=0, sticky flags=0, in_ready=0, out_valid=0, out_data=0,
//    out_sat=0. Reset mid-transaction discards partial sums. in_ready=1 from the first
//    edge after release.
//  - FSM: IDLE -> ACCUM on accepted beat with in_last=0; IDLE/ACCUM -> OUTPUT on accepted
//    beat with in_last=1; OUTPUT -> IDLE when out_valid && out_ready.
//  - Beat accepted iff in_valid && in_ready. in_ready = (state != OUTPUT). Bubbles
//    (in_valid=0) leave accumulators unchanged in any state.
//  - Accept in IDLE: acc = sext(in) (starts fresh). Accept in ACCUM: acc = sat(acc + sext(in)).
//  - Accumulator saturates at [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; any clamp sets a
//    per-lane sticky flag, cleared when the next transaction starts.
//  - Final value: v = acc_final + (ROUND && OUT_SCALE>0 ? 2^(OUT_SCALE-1) : 0), computed
//    in ACC_WIDTH+1 bits (no overflow), then v >>> OUT_SCALE, then clamp to OUT_WIDTH.
//    out_sat[i] = sticky[i] | output clamp.
//  - Latency: out_data/out_sat/out_valid registered; out_valid=1 on the edge that accepts
//    the last beat, i.e. visible the cycle after. Single-beat transaction is legal.
//  - out_data/out_sat held stable while out_valid && !out_ready. No input accepted in
//    OUTPUT. After handshake: out_valid=0, in_ready=1 next cycle (one-bubble turnaround).
//  - out_data is not cleared after the handshake; ignore it when out_valid=0.
// TESTING (LANES=2, IN_WIDTH=8, ACC_WIDTH=12, OUT_WIDTH=8, OUT_SCALE=2, ROUND=1)
//  1 single beat lane0=5, lane1=-6, last=1 -> next cycle out_valid=1, out=(1,-1), sat=00
//  2 3 beats lane0=100, lane1=-100 (last on 3rd) -> out=(75,-75), sat=00
//  3 20 beats lane0=127, lane1=-128 -> acc clamps 2047/-2048; out=(127,-128), sat=11;
//    next transaction 1 beat (4,4) -> out=(1,1), sat=00 (sticky flags cleared)
//  4 out_ready=0 for 5 cycles after result -> out_data/out_sat stable, in_ready=0, in beats
//    offered meanwhile not consumed; out_ready=1 -> out_valid=0, in_ready=1 next cycle
//  5 2 beats accepted, then arst_n_in=0 for 1 cycle -> all outputs 0; new 1-beat txn
//    (8,-8) -> out=(2,-2), no leftover sum
//  6 beats with random in_valid gaps (30% bubbles) vs golden model -> bit-exact results

Source files
------------

// File: rtl/stream_scaled_accumulator.sv
// Multi-lane streaming accumulator: sums signed beats per lane with saturation, then
// rounds, scales and clamps one result per transaction behind a valid/ready handshake.
module stream_scaled_accumulator #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 0,
  parameter int ROUND     = 1
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [LANES*IN_WIDTH-1:0]      in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*OUT_WIDTH-1:0]     out_data,
  output logic [LANES-1:0]               out_sat
);

  // state    | meaning
  // S_IDLE   | waiting for the first beat of a transaction
  // S_ACCUM  | mid-transaction, adding beats into the accumulators
  // S_OUTPUT | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  localparam logic [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH:0] OUT_MAX = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH:0] OUT_MIN = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam int                 RND_SH  = (OUT_SCALE > 0) ? OUT_SCALE - 1 : 0;
  localparam logic [ACC_WIDTH:0] RND_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH:0] RND     = (ROUND != 0 && OUT_SCALE > 0) ? (RND_ONE << RND_SH) : '0;

  state_e                               state_q, state_d;
  logic [LANES-1:0][ACC_WIDTH-1:0]      acc_q, acc_d, acc_nxt;
  logic [LANES-1:0]                     sticky_q, sticky_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 out_valid_q, out_valid_d;
  logic [LANES*OUT_WIDTH-1:0]           out_data_q, out_data_d;
  logic [LANES-1:0]                     out_sat_q, out_sat_d;
  logic [LANES-1:0][OUT_WIDTH-1:0]      res;
  logic [LANES-1:0]                     acc_clamp, out_clamp;
  logic                                 accept;

  assign accept = in_valid && in_ready_q;

  // Per-lane datapath: next accumulator value and the result it would produce if this
  // beat is the last one. Sums are formed one bit wider so overflow is visible.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IN_WIDTH-1:0]  x;
    logic [ACC_WIDTH:0]   x_ext, acc_ext, sum, v, sh;
    logic                 sum_hi, sum_lo, o_hi, o_lo;

    assign x       = in_data[i*IN_WIDTH +: IN_WIDTH];
    assign x_ext   = {{(ACC_WIDTH+1-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    assign acc_ext = {acc_q[i][ACC_WIDTH-1], acc_q[i]};
    assign sum     = acc_ext + x_ext;
    assign sum_hi  = $signed(sum) > $signed(ACC_MAX);
    assign sum_lo  = $signed(sum) < $signed(ACC_MIN);

    assign acc_nxt[i]   = (state_q == S_IDLE) ? x_ext[ACC_WIDTH-1:0] :
                          sum_hi ? ACC_MAX[ACC_WIDTH-1:0] :
                          sum_lo ? ACC_MIN[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
    assign acc_clamp[i] = (state_q != S_IDLE) && (sum_hi || sum_lo);

    assign v    = {acc_nxt[i][ACC_WIDTH-1], acc_nxt[i]} + RND;
    assign sh   = $signed(v) >>> OUT_SCALE;
    assign o_hi = $signed(sh) > $signed(OUT_MAX);
    assign o_lo = $signed(sh) < $signed(OUT_MIN);

    assign res[i]       = o_hi ? OUT_MAX[OUT_WIDTH-1:0] :
                          o_lo ? OUT_MIN[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
    assign out_clamp[i] = o_hi || o_lo;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d    = acc_nxt;
          sticky_d = (state_q == S_ACCUM) ? (sticky_q | acc_clamp) : '0;
          if (in_last) begin
            state_d     = S_OUTPUT;
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_sat_d   = sticky_d | out_clamp;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so it stays low through reset and rises on the first edge after release.
    in_ready_d = (state_d != S_OUTPUT);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      sticky_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_stream_scaled_accumulator.sv
// Bench for stream_scaled_accumulator: directed scenarios plus randomized transactions
// compared against an integer reference model of the accumulate/round/scale rules.
module tb_stream_scaled_accumulator;
  localparam int LANES = 2;
  localparam int IW    = 8;
  localparam int AW    = 12;
  localparam int OW    = 8;
  localparam int SC    = 2;
  localparam int RD    = 1;
  localparam int ACC_HI = (1 << (AW-1)) - 1;
  localparam int ACC_LO = -(1 << (AW-1));
  localparam int OUT_HI = (1 << (OW-1)) - 1;
  localparam int OUT_LO = -(1 << (OW-1));

  logic                   clk = 1'b0;
  logic                   arst_n_in = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_last = 1'b0;
  logic [LANES*IW-1:0]    in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [LANES*OW-1:0]    out_data;
  logic [LANES-1:0]       out_sat;

  stream_scaled_accumulator #(
    .LANES(LANES), .IN_WIDTH(IW), .ACC_WIDTH(AW),
    .OUT_WIDTH(OW), .OUT_SCALE(SC), .ROUND(RD)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: running sums per lane and the result of the last transaction.
  int               m_acc [LANES];
  bit               m_st  [LANES];
  bit               m_fresh = 1'b1;
  logic [LANES*OW-1:0] m_exp_data = '0;
  logic [LANES-1:0]    m_exp_sat  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_accept(input int a, input int b, input bit last);
    int v [LANES];
    int r;
    bit s;
    v[0] = a;
    v[1] = b;
    for (int l = 0; l < LANES; l++) begin
      if (m_fresh) begin
        m_acc[l] = v[l];
        m_st[l]  = 1'b0;
      end else begin
        m_acc[l] = m_acc[l] + v[l];
        if (m_acc[l] > ACC_HI) begin m_acc[l] = ACC_HI; m_st[l] = 1'b1; end
        if (m_acc[l] < ACC_LO) begin m_acc[l] = ACC_LO; m_st[l] = 1'b1; end
      end
    end
    m_fresh = last;
    if (last) begin
      for (int l = 0; l < LANES; l++) begin
        r = (m_acc[l] + ((RD != 0 && SC > 0) ? (1 << (SC-1)) : 0)) >>> SC;
        s = m_st[l];
        if (r > OUT_HI) begin r = OUT_HI; s = 1'b1; end
        if (r < OUT_LO) begin r = OUT_LO; s = 1'b1; end
        m_exp_data[l*OW +: OW] = OW'(r);
        m_exp_sat[l]           = s;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input bit last);
    int n = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_last  = last;
    in_data  = {IW'(b), IW'(a)};
    do begin
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      m_accept(a, b, last);
      if (last) chk("latency_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic take(input int stall, input string tag);
    int n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      step();
      chk({tag, "_hold_data"}, 32'(out_data), 32'(m_exp_data));
      chk({tag, "_hold_sat"}, 32'(out_sat), 32'(m_exp_sat));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    chk({tag, "_data"}, 32'(out_data), 32'(m_exp_data));
    chk({tag, "_sat"}, 32'(out_sat), 32'(m_exp_sat));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, mode, va, vb;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    step();
    arst_n_in = 1'b1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    // 1: single beat
    send(5, -6, 1'b1);
    chk("t1_spec_data", 32'(out_data), 32'h0000_FF01);
    chk("t1_spec_sat", 32'(out_sat), 32'd0);
    take(0, "t1");

    // 2: three beats
    send(100, -100, 1'b0);
    send(100, -100, 1'b0);
    send(100, -100, 1'b1);
    chk("t2_spec_data", 32'(out_data), 32'h0000_B54B);
    chk("t2_spec_sat", 32'(out_sat), 32'd0);
    take(0, "t2");

    // 3: accumulator saturation, then sticky flags cleared by the next transaction
    for (int k = 0; k < 20; k++) send(127, -128, k == 19);
    chk("t3_spec_data", 32'(out_data), 32'h0000_807F);
    chk("t3_spec_sat", 32'(out_sat), 32'd3);
    take(0, "t3");
    send(4, 4, 1'b1);
    chk("t3b_spec_data", 32'(out_data), 32'h0000_0101);
    chk("t3b_spec_sat", 32'(out_sat), 32'd0);
    take(0, "t3b");

    // 4: back-pressure with a beat offered during the stall
    send(10, 20, 1'b0);
    send(30, -50, 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = {8'sd99, 8'sd99};
    take(5, "t4");
    in_last = 1'b0;
    send(6, 9, 1'b1);
    chk("t4b_spec_data", 32'(out_data), 32'h0000_0202);
    take(0, "t4b");

    // 5: reset mid-transaction
    send(50, 60, 1'b0);
    send(7, 7, 1'b0);
    arst_n_in = 1'b0;
    #2;
    chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_out_data", 32'(out_data), 32'd0);
    chk("t5_rst_out_sat", 32'(out_sat), 32'd0);
    step();
    arst_n_in = 1'b1;
    m_fresh   = 1'b1;
    step();
    send(8, -8, 1'b1);
    chk("t5_spec_data", 32'(out_data), 32'h0000_FE02);
    take(0, "t5");

    // 6: randomized transactions with input bubbles and output stalls
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 3);
      nb   = (mode == 0) ? $urandom_range(15, 25) : $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        for (int g = 0; g < 4 && $urandom_range(0, 99) < 30; g++) begin
          in_valid = 1'b0;
          step();
        end
        if (mode == 0) begin
          va = $urandom_range(100, 127);
          vb = -int'($urandom_range(100, 128));
        end else begin
          va = int'($urandom_range(0, 255)) - 128;
          vb = int'($urandom_range(0, 255)) - 128;
        end
        send(va, vb, b == nb - 1);
      end
      take($urandom_range(0, 3), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
